// File: rtl/chess_timer_pkg.sv
// Shared definitions for the chess timer: state encodings decoded by the display
// driver and default clock/time widths.
package chess_timer_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned TIME_W_DEF = 10;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] STATE_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] STATE_RUN1   = 3'd1;
  localparam logic [STATE_W-1:0] STATE_RUN2   = 3'd2;
  localparam logic [STATE_W-1:0] STATE_PAUSED = 3'd3;
  localparam logic [STATE_W-1:0] STATE_FLAG   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = STATE_IDLE,
    ST_RUN1   = STATE_RUN1,
    ST_RUN2   = STATE_RUN2,
    ST_PAUSED = STATE_PAUSED,
    ST_FLAG   = STATE_FLAG
  } state_e;

endpackage

// File: rtl/chess_clock_scheduler_if.sv
// Button/pause inputs and time/status outputs between the board, the scheduler
// and the display driver.
interface chess_clock_scheduler_if #(
  parameter int unsigned TIME_W = 10
);

  logic [1:0]        buttons;
  logic              pause;
  logic [TIME_W-1:0] time_1;
  logic [TIME_W-1:0] time_2;
  logic [1:0]        active;
  logic [1:0]        flag;
  logic [2:0]        state_disp;
  logic              tick;

  modport master (
    output buttons, pause,
    input  time_1, time_2, active, flag, state_disp, tick
  );

  modport slave (
    input  buttons, pause,
    output time_1, time_2, active, flag, state_disp, tick
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-second tick; holds its count while not
// running so a pause keeps the partial second.
module tick_prescaler
  import chess_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned    CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over run, terminal count wraps and fires the tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chess_clock_scheduler.sv
// Two-player chess clock controller: button edge detection, run/pause/flag FSM,
// Fischer increment and per-second decrement of both players' remaining time.
module chess_clock_scheduler
  import chess_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
  parameter int unsigned TIME_W    = TIME_W_DEF,
  parameter int unsigned START_SEC = 300,
  parameter int unsigned INC_SEC   = 2
) (
  input logic                    clk,
  input logic                    reset,
  chess_clock_scheduler_if.slave bus
);

  localparam logic [TIME_W-1:0] START_V = TIME_W'(START_SEC);
  localparam logic [TIME_W-1:0] INC_V   = TIME_W'(INC_SEC);
  localparam logic [TIME_W-1:0] ONE_V   = TIME_W'(1);
  localparam logic [TIME_W-1:0] MAX_V   = {TIME_W{1'b1}};

  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    logic [TIME_W:0] sum;
    sum = {1'b0, v} + {1'b0, INC_V};
    if (sum[TIME_W]) begin
      sat_inc = MAX_V;
    end else begin
      sat_inc = sum[TIME_W-1:0];
    end
  endfunction

  state_e            state_q, state_d;
  logic              paused_p1_q, paused_p1_d;
  logic [1:0]        btn_q;
  logic [TIME_W-1:0] time1_q, time1_d;
  logic [TIME_W-1:0] time2_q, time2_d;
  logic [1:0]        flag_q, flag_d;
  logic [1:0]        active_q, active_d;
  logic              tick_q;

  logic [1:0] press_s;
  logic       running_s;
  logic       sw_to2_s;
  logic       sw_to1_s;
  logic       switch_s;
  logic       start_s;
  logic       run_s;
  logic       clear_s;
  logic       sec_tick_s;

  assign press_s   = bus.buttons & ~btn_q;
  assign running_s = (state_q == ST_RUN1) || (state_q == ST_RUN2);
  assign sw_to2_s  = (state_q == ST_RUN1) && (press_s == 2'b10);
  assign sw_to1_s  = (state_q == ST_RUN2) && (press_s == 2'b01);
  assign switch_s  = sw_to2_s || sw_to1_s;
  assign start_s   = (state_q == ST_IDLE) && ((press_s == 2'b01) || (press_s == 2'b10));
  // A switch or a pause in this cycle pre-empts the tick, so the prescaler must not advance.
  assign run_s     = running_s && !switch_s && !bus.pause;
  assign clear_s   = start_s || switch_s;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run_s),
    .clear (clear_s),
    .tick  (sec_tick_s)
  );

  // Next state, time and flag: switch press > pause > tick.
  always_comb begin
    state_d     = state_q;
    paused_p1_d = paused_p1_q;
    time1_d     = time1_q;
    time2_d     = time2_q;
    flag_d      = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (press_s == 2'b01) begin
          state_d = ST_RUN1;
        end else if (press_s == 2'b10) begin
          state_d = ST_RUN2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN1: begin
        if (sw_to2_s) begin
          state_d = ST_RUN2;
          time1_d = sat_inc(time1_q);
        end else if (bus.pause) begin
          state_d     = ST_PAUSED;
          paused_p1_d = 1'b0;
        end else if (sec_tick_s) begin
          if (time1_q == ONE_V) begin
            state_d   = ST_FLAG;
            flag_d[0] = 1'b1;
            time1_d   = '0;
          end else begin
            time1_d = time1_q - ONE_V;
          end
        end else begin
          state_d = ST_RUN1;
        end
      end
      ST_RUN2: begin
        if (sw_to1_s) begin
          state_d = ST_RUN1;
          time2_d = sat_inc(time2_q);
        end else if (bus.pause) begin
          state_d     = ST_PAUSED;
          paused_p1_d = 1'b1;
        end else if (sec_tick_s) begin
          if (time2_q == ONE_V) begin
            state_d   = ST_FLAG;
            flag_d[1] = 1'b1;
            time2_d   = '0;
          end else begin
            time2_d = time2_q - ONE_V;
          end
        end else begin
          state_d = ST_RUN2;
        end
      end
      ST_PAUSED: begin
        if (!bus.pause) begin
          state_d = paused_p1_q ? ST_RUN2 : ST_RUN1;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_FLAG: begin
        state_d = ST_FLAG;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Running-clock indication derived from the next state so it lines up with state_disp.
  always_comb begin
    active_d = 2'b00;
    case (state_d)
      ST_RUN1: active_d = 2'b01;
      ST_RUN2: active_d = 2'b10;
      default: active_d = 2'b00;
    endcase
  end

  // State, time and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      paused_p1_q <= 1'b0;
      btn_q       <= 2'b00;
      time1_q     <= START_V;
      time2_q     <= START_V;
      flag_q      <= 2'b00;
      active_q    <= 2'b00;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      paused_p1_q <= paused_p1_d;
      btn_q       <= bus.buttons;
      time1_q     <= time1_d;
      time2_q     <= time2_d;
      flag_q      <= flag_d;
      active_q    <= active_d;
      tick_q      <= sec_tick_s;
    end
  end

  assign bus.time_1     = time1_q;
  assign bus.time_2     = time2_q;
  assign bus.active     = active_q;
  assign bus.flag       = flag_q;
  assign bus.state_disp = state_q;
  assign bus.tick       = tick_q;

endmodule

// File: tb/tb_chess_clock_scheduler.sv
// Bench for chess_clock_scheduler: directed scenarios plus random button/pause
// traffic, all compared against a behavioural model of the game rules.
module tb_chess_clock_scheduler;

  localparam int CLK_HZ    = 4;
  localparam int TIME_W    = 10;
  localparam int START_SEC = 3;
  localparam int INC_SEC   = 2;
  localparam int TMAX      = (1 << TIME_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chess_clock_scheduler_if #(.TIME_W(TIME_W)) bus ();

  chess_clock_scheduler #(
    .CLK_HZ    (CLK_HZ),
    .TIME_W    (TIME_W),
    .START_SEC (START_SEC),
    .INC_SEC   (INC_SEC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0=idle 1=running 2=paused 3=flagged; pl = player whose clock runs/was running
  int m_mode, m_pl, m_phase, m_tick;
  int m_t[2];
  int m_flag[2];
  int m_prev[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pl = 0; m_phase = 0; m_tick = 0;
    m_t[0] = START_SEC; m_t[1] = START_SEC;
    m_flag[0] = 0; m_flag[1] = 0;
    m_prev[0] = 0; m_prev[1] = 0;
  endtask

  task automatic model_step(input logic [1:0] b, input logic p);
    int pr[2];
    int own, oth;
    pr[0] = (b[0] && m_prev[0] == 0) ? 1 : 0;
    pr[1] = (b[1] && m_prev[1] == 0) ? 1 : 0;
    m_prev[0] = int'(b[0]);
    m_prev[1] = int'(b[1]);
    m_tick = 0;
    case (m_mode)
      0: begin
        if (pr[0] == 1 && pr[1] == 0) begin m_mode = 1; m_pl = 0; m_phase = 0; end
        else if (pr[1] == 1 && pr[0] == 0) begin m_mode = 1; m_pl = 1; m_phase = 0; end
      end
      1: begin
        own = pr[m_pl];
        oth = pr[1 - m_pl];
        if (oth == 1 && own == 0) begin
          m_t[m_pl] = (m_t[m_pl] + INC_SEC > TMAX) ? TMAX : m_t[m_pl] + INC_SEC;
          m_pl = 1 - m_pl;
          m_phase = 0;
        end else if (p) begin
          m_mode = 2;
        end else if (m_phase == CLK_HZ - 1) begin
          m_phase = 0;
          m_tick = 1;
          m_t[m_pl] = m_t[m_pl] - 1;
          if (m_t[m_pl] == 0) begin
            m_mode = 3;
            m_flag[m_pl] = 1;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end
      2: if (!p) m_mode = 1;
      default: ;
    endcase
  endtask

  function automatic int exp_state();
    case (m_mode)
      0: return 0;
      1: return (m_pl == 1) ? 2 : 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  task automatic compare_all();
    check_val("state_disp", 32'(bus.state_disp), exp_state());
    check_val("time_1", 32'(bus.time_1), m_t[0]);
    check_val("time_2", 32'(bus.time_2), m_t[1]);
    check_val("active", 32'(bus.active), (m_mode == 1) ? ((m_pl == 1) ? 2 : 1) : 0);
    check_val("flag", 32'(bus.flag), m_flag[1] * 2 + m_flag[0]);
    check_val("tick", 32'(bus.tick), m_tick);
  endtask

  task automatic cycle(input logic [1:0] b, input logic p);
    bus.buttons = b;
    bus.pause   = p;
    @(posedge clk);
    model_step(b, p);
    @(negedge clk);
    compare_all();
  endtask

  // asserts reset mid low-phase and checks outputs before any clock edge
  task automatic do_reset(input string tag);
    bus.buttons = 2'b00;
    bus.pause   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_val({tag, "_state"}, 32'(bus.state_disp), 0);
    check_val({tag, "_t1"}, 32'(bus.time_1), START_SEC);
    check_val({tag, "_t2"}, 32'(bus.time_2), START_SEC);
    check_val({tag, "_active"}, 32'(bus.active), 0);
    check_val({tag, "_flag"}, 32'(bus.flag), 0);
    check_val({tag, "_tick"}, 32'(bus.tick), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int ticks_seen;
    int t1_before;
    logic [1:0] rb;
    logic rp;

    reset = 1'b1;
    bus.buttons = 2'b00;
    bus.pause   = 1'b0;
    @(negedge clk);
    do_reset("por");

    // idle
    ticks_seen = 0;
    repeat (20) begin
      cycle(2'b00, 1'b0);
      ticks_seen = ticks_seen + int'(bus.tick);
    end
    check_val("idle_ticks", ticks_seen, 0);

    // start player 0, held level gives a single press
    cycle(2'b01, 1'b0);
    check_val("start_state", 32'(bus.state_disp), 1);
    ticks_seen = 0;
    repeat (8) begin
      cycle(2'b01, 1'b0);
      ticks_seen = ticks_seen + int'(bus.tick);
    end
    check_val("run_ticks", ticks_seen, 2);
    check_val("run_t1", 32'(bus.time_1), 1);
    check_val("run_t2", 32'(bus.time_2), 3);

    // switch exactly on a tick cycle: increment only
    repeat (3) cycle(2'b00, 1'b0);
    cycle(2'b10, 1'b0);
    check_val("sw_state", 32'(bus.state_disp), 2);
    check_val("sw_t1", 32'(bus.time_1), 3);
    check_val("sw_tick", 32'(bus.tick), 0);
    repeat (4) cycle(2'b00, 1'b0);
    check_val("sw_restart_tick", 32'(bus.tick), 1);

    // back to player 0, pause two cycles into a second
    cycle(2'b01, 1'b0);
    repeat (2) cycle(2'b00, 1'b0);
    t1_before = int'(bus.time_1);
    repeat (10) cycle(2'b00, 1'b1);
    check_val("pause_state", 32'(bus.state_disp), 3);
    check_val("pause_t1", 32'(bus.time_1), t1_before);
    cycle(2'b11, 1'b0);
    check_val("resume_state", 32'(bus.state_disp), 1);
    cycle(2'b11, 1'b0);
    check_val("resume_tick1", 32'(bus.tick), 0);
    cycle(2'b00, 1'b0);
    check_val("resume_tick2", 32'(bus.tick), 1);

    // hand to player 1 and let it expire
    cycle(2'b10, 1'b0);
    for (int i = 0; i < 200 && m_mode != 3; i++) cycle(2'b00, 1'b0);
    check_val("flag_state", 32'(bus.state_disp), 4);
    check_val("flag_bits", 32'(bus.flag), 2);
    check_val("flag_active", 32'(bus.active), 0);
    check_val("flag_t2", 32'(bus.time_2), 0);
    for (int i = 0; i < 20; i++) cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // saturation by rapid alternation
    do_reset("rst_sat");
    cycle(2'b01, 1'b0);
    repeat (4) cycle(2'b00, 1'b0);
    check_val("sat_pre_t1", 32'(bus.time_1), 2);
    for (int i = 0; i < 1030; i++) cycle((i % 2 == 0) ? 2'b10 : 2'b01, 1'b0);
    check_val("sat_t1", 32'(bus.time_1), TMAX);

    // both buttons together in IDLE and in RUN1
    do_reset("rst_both");
    cycle(2'b11, 1'b0);
    check_val("both_idle", 32'(bus.state_disp), 0);
    cycle(2'b00, 1'b0);
    cycle(2'b01, 1'b0);
    cycle(2'b00, 1'b0);
    cycle(2'b11, 1'b0);
    check_val("both_run1", 32'(bus.state_disp), 1);

    // reset in the middle of RUN2
    cycle(2'b00, 1'b0);
    cycle(2'b10, 1'b0);
    repeat (3) cycle(2'b00, 1'b0);
    check_val("pre_rst_state", 32'(bus.state_disp), 2);
    do_reset("rst_run2");

    // random traffic
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 400; i++) begin
        rb = 2'($urandom_range(0, 3));
        rp = ($urandom_range(0, 7) == 0);
        cycle(rb, rp);
      end
      do_reset("rst_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
